// File: rtl/pll_reconfig_ctrl.sv
// Gowin PLLA dynamic-reconfiguration sequencer: holds the PLL in reset, writes
// (and optionally verifies) one stored divider profile over the MD port, then waits for lock.
module pll_reconfig_ctrl #(
  parameter int NUM_PROFILES     = 4,
  parameter int REGS_PER_PROFILE = 8,
  parameter logic [NUM_PROFILES*REGS_PER_PROFILE*16-1:0] PROFILE_TABLE = '0,
  parameter bit VERIFY           = 1'b1,
  parameter int RST_HOLD         = 4,
  parameter int LOCK_TIMEOUT     = 65535
) (
  input  logic       mdclk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [3:0] req_profile,
  output logic       req_ready,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code,
  output logic [3:0] cur_profile,
  output logic       cfg_valid,
  output logic       pll_reset,
  input  logic       lock,
  output logic [1:0] mdopc,
  output logic       mdainc,
  output logic [7:0] mdwdi,
  input  logic [7:0] mdrdo
);

  localparam int PW = (NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1;
  localparam int KW = (REGS_PER_PROFILE > 1) ? $clog2(REGS_PER_PROFILE) : 1;
  localparam logic [4:0]    NUM_PROF_L = 5'(NUM_PROFILES);
  localparam logic [KW-1:0] LAST_K     = KW'(REGS_PER_PROFILE - 1);
  localparam logic [16:0]   HOLD_LIMIT = 17'(RST_HOLD);
  localparam logic [16:0]   LOCK_LIMIT = 17'(LOCK_TIMEOUT);

  localparam logic [1:0] OP_NOP     = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_READ    = 2'b10;
  localparam logic [1:0] OP_SETADDR = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_ASSERT_RST, S_SETADDR, S_WRITE, S_RB_ADDR, S_READ,
    S_CHECK, S_NEXT, S_HOLD, S_WAIT_LOCK, S_FAIL
  } state_t;

  state_t        state, state_next;
  logic          lock_m, lock_s;
  logic [3:0]    prof;
  logic [KW-1:0] k;
  logic [15:0]   cnt;
  logic [16:0]   cnt_inc;
  logic [15:0]   entries [NUM_PROFILES][REGS_PER_PROFILE];
  logic [15:0]   entry;
  logic          accept, bad_req, rst_window;

  for (genvar p = 0; p < NUM_PROFILES; p++) begin : g_prof
    for (genvar e = 0; e < REGS_PER_PROFILE; e++) begin : g_entry
      assign entries[p][e] = PROFILE_TABLE[(p*REGS_PER_PROFILE+e)*16 +: 16];
    end
  end

  assign entry     = entries[prof[PW-1:0]][k];
  assign cnt_inc   = {1'b0, cnt} + 17'd1;
  // Blocking acceptance during the done cycle keeps done and a bad-index error apart.
  assign req_ready = (state == S_IDLE) && !done;
  assign busy      = (state != S_IDLE);
  assign mdainc    = 1'b0;
  assign accept    = req_valid && req_ready;
  assign bad_req   = accept && ({1'b0, req_profile} >= NUM_PROF_L);
  assign error     = bad_req || (state == S_FAIL);

  always_comb begin
    state_next = state;
    mdopc      = OP_NOP;
    mdwdi      = 8'h00;
    rst_window = 1'b0;
    unique case (state)
      S_IDLE:       if (accept && !bad_req) state_next = S_ASSERT_RST;
      S_ASSERT_RST: state_next = S_SETADDR;
      S_SETADDR: begin
        mdopc      = OP_SETADDR;
        mdwdi      = entry[15:8];
        state_next = S_WRITE;
      end
      S_WRITE: begin
        mdopc      = OP_WRITE;
        mdwdi      = entry[7:0];
        state_next = VERIFY ? S_RB_ADDR : S_NEXT;
      end
      S_RB_ADDR: begin
        mdopc      = OP_SETADDR;
        mdwdi      = entry[15:8];
        state_next = S_READ;
      end
      S_READ: begin
        mdopc      = OP_READ;
        state_next = S_CHECK;
      end
      S_CHECK:      state_next = (mdrdo == entry[7:0]) ? S_NEXT : S_FAIL;
      S_NEXT:       state_next = (k == LAST_K) ? S_HOLD : S_SETADDR;
      S_HOLD:       if (cnt_inc >= HOLD_LIMIT) state_next = S_WAIT_LOCK;
      // The timeout fires on the edge where the count reaches LOCK_TIMEOUT.
      S_WAIT_LOCK: begin
        if (lock_s) state_next = S_IDLE;
        else if (cnt_inc >= LOCK_LIMIT) state_next = S_FAIL;
      end
      S_FAIL:       state_next = S_IDLE;
      default:      state_next = S_IDLE;
    endcase
    rst_window = (state_next inside {S_ASSERT_RST, S_SETADDR, S_WRITE, S_RB_ADDR,
                                     S_READ, S_CHECK, S_NEXT, S_HOLD});
  end

  always_ff @(posedge mdclk) begin
    if (reset) begin
      state       <= S_IDLE;
      lock_m      <= 1'b0;
      lock_s      <= 1'b0;
      prof        <= 4'd0;
      k           <= '0;
      cnt         <= 16'd0;
      pll_reset   <= 1'b0;
      done        <= 1'b0;
      err_code    <= 2'd0;
      cur_profile <= 4'd0;
      cfg_valid   <= 1'b1;
    end else begin
      state     <= state_next;
      lock_m    <= lock;
      lock_s    <= lock_m;
      pll_reset <= rst_window;
      done      <= (state == S_WAIT_LOCK) && lock_s;

      if (state_next != state || !(state inside {S_HOLD, S_WAIT_LOCK})) cnt <= 16'd0;
      else cnt <= cnt_inc[15:0];

      if (accept) begin
        if (bad_req) begin
          err_code <= 2'd1;
        end else begin
          prof      <= req_profile;
          err_code  <= 2'd0;
          cfg_valid <= 1'b0;
          k         <= '0;
        end
      end

      if (state == S_NEXT && k != LAST_K) k <= k + 1'b1;

      if (state_next == S_FAIL) err_code <= (state == S_CHECK) ? 2'd2 : 2'd3;

      if (state == S_WAIT_LOCK && lock_s) begin
        cur_profile <= prof;
        cfg_valid   <= 1'b1;
      end
    end
  end

endmodule

// File: doc/pll_reconfig_ctrl.md
# pll_reconfig_ctrl

Sequencer that reprograms a Gowin PLLA through its dynamic-reconfiguration (MD) port. It selects one of NUM_PROFILES stored divider profiles, holds the PLL in reset, writes and optionally read-back-verifies each register, then releases reset and waits for lock. It sits between the board clocking wrapper's MD port and the video/system mode logic, so output clock frequencies can change at run time without a new bitstream.

## Interface

- NUM_PROFILES, 4: number of stored profiles, 1..16
- REGS_PER_PROFILE, 8: {addr,data} entries per profile, 1..32
- PROFILE_TABLE, all zero: flat vector of NUM_PROFILES*REGS_PER_PROFILE*16 bits; entry k of profile p is at bits [(p*REGS_PER_PROFILE+k)*16 +: 16], {addr[15:8], data[7:0]}
- VERIFY, 1: 1 = read back and compare each written register
- RST_HOLD, 4: minimum cycles pll_reset stays high after the last write
- LOCK_TIMEOUT, 65535: WAIT_LOCK cycle limit

Ports:
- mdclk  in  1  controller clock; also drives the PLL MDCLK
- reset  in  1  synchronous, active-high
- req_valid  in  1  reconfiguration request
- req_profile  in  4  requested profile index
- req_ready  out  1  high only in IDLE
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on successful completion
- error  out  1  one-cycle pulse on a bad index, verify mismatch, or lock timeout
- err_code  out  2  0 none, 1 bad index, 2 mismatch, 3 timeout; holds until the next accepted request
- cur_profile  out  4  last successfully applied profile
- cfg_valid  out  1  PLL is running cur_profile and is locked
- pll_reset  out  1  drives PLL RESET
- lock  in  1  PLL LOCK, asynchronous
- mdopc  out  2  00 NOP, 01 WRITE, 10 READ, 11 SETADDR
- mdainc  out  1  tied 0; address is always set explicitly
- mdwdi  out  8  address (SETADDR) or data (WRITE)
- mdrdo  in  8  read data, valid the cycle after READ

## Operation

- Reset values: state IDLE, mdopc 00, mdwdi 0, mdainc 0, pll_reset 0, busy 0, done 0, error 0, err_code 0, cur_profile 0, cfg_valid 1. Profile 0 must equal the bitstream defaults.
- lock passes through a 2-flop synchronizer to lock_s before any use.
- Request acceptance: req_valid && req_ready in one cycle.
  - If req_profile >= NUM_PROFILES: pulse error, set err_code 1, stay in IDLE, leave cfg_valid unchanged, issue no MD traffic.
  - Otherwise: latch the profile, clear err_code, set entry index k=0, set cfg_valid 0, go to ASSERT_RST.
- State sequence:
  - ASSERT_RST: pll_reset←1, then SETADDR.
  - SETADDR: mdopc 11, mdwdi=addr[k], then WRITE.
  - WRITE: mdopc 01, mdwdi=data[k]. Next state is RB_ADDR if VERIFY, otherwise NEXT.
  - RB_ADDR: mdopc 11, mdwdi=addr[k].
  - READ: mdopc 10.
  - CHECK: mdopc 00, compare mdrdo with data[k]. On mismatch go to FAIL with code 2.
  - NEXT: if k==REGS_PER_PROFILE-1 go to HOLD; otherwise k++ and go to SETADDR.
  - HOLD: count RST_HOLD cycles, then pll_reset←0 and go to WAIT_LOCK.
  - WAIT_LOCK: when lock_s=1, set cur_profile←latched profile, cfg_valid←1, pulse done, go to IDLE. If the counter reaches LOCK_TIMEOUT first, go to FAIL with code 3.
  - FAIL: pll_reset←0, pulse error, cfg_valid stays 0, cur_profile unchanged, go to IDLE.
- mdopc is 00 in every state not listed above with an operation.
- req_valid while busy is ignored. The requester must hold it until accepted.
- Synchronous reset mid-sequence aborts immediately to reset values, including pll_reset 0. The PLL may hold a partial profile; a new request is required.

## Timing

- Every MD operation occupies exactly one mdclk cycle. Back-to-back operations are legal.
- Cycles from accept to the start of HOLD: 1 + REGS_PER_PROFILE*(VERIFY ? 6 : 3).
- HOLD lasts exactly RST_HOLD cycles.
- done asserts the cycle after lock_s is first seen high, which is 2–3 mdclk after lock rises, counting from the end of HOLD.
- The WAIT_LOCK counter is 16 bits, starts at 0 on entry, and never wraps. Timeout occurs at count == LOCK_TIMEOUT.
- done and error never assert in the same cycle.

## Test plan

- Request profile 2 with VERIFY=1, REGS_PER_PROFILE=8, and a PLL model that echoes writes, lock rising 100 cycles after reset release -> exactly 8 SETADDR/WRITE pairs with the table addresses and data, pll_reset high for 1+48+4 cycles, done pulse, cur_profile=2, cfg_valid=1.
- Request profile 5 with NUM_PROFILES=4 -> same-cycle error pulse, err_code=1, no mdopc activity, cfg_valid stays 1.
- Model corrupts the readback of entry 3 (returns data^8'h01) -> FAIL after the 4th CHECK, err_code=2, pll_reset 0, cfg_valid 0, cur_profile unchanged.
- lock held 0 with LOCK_TIMEOUT=20 -> error exactly 20 cycles after entering WAIT_LOCK, err_code=3.
- Second req_valid pulsed while busy, then reset asserted during the 5th WRITE -> second request ignored; after reset all outputs at reset values and mdopc=00 from the next cycle.
- VERIFY=0 -> no READ ops, accept-to-HOLD time = 25 cycles for 8 entries.
